ls_agu: RTL

Load/store address-generation stage directly downstream of the load/store issue queue. It consumes the issue_load0 and issue_st0 valid/ready handshakes together with same-cycle register-file operand values. It computes vaddr = src1 + imm and checks natural alignment, then registers one result per port toward the load pipe and the store queue. Flush-aware: entries younger than a redirect are squashed in flight.

---
 rtl/ls_pkg.sv | 40 ++++
 rtl/ls_agu_if.sv | 82 ++++++++
 rtl/agu_slot.sv | 84 ++++++++
 rtl/ls_agu.sv | 108 ++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ls_pkg
// Brief    : Shared load/store types, access-size encodings and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ls_pkg;

    localparam int c_ROB_W = 7;
    localparam int c_SQ_W  = 5;

    typedef logic [3:0]         ls_size_t;
    typedef logic [c_ROB_W-1:0] rob_id_t;
    typedef logic [c_SQ_W-1:0]  sq_id_t;

    localparam ls_size_t c_SIZE_B = 4'b0001;
    localparam ls_size_t c_SIZE_H = 4'b0010;
    localparam ls_size_t c_SIZE_W = 4'b0100;
    localparam ls_size_t c_SIZE_D = 4'b1000;

    // The MSB is the wrap bit: differing wrap bits flip the index ordering.
    function automatic logic rob_younger(input rob_id_t a, input rob_id_t b);
        logic [c_ROB_W-2:0] a_idx;
        logic [c_ROB_W-2:0] b_idx;
        a_idx = a[c_ROB_W-2:0];
        b_idx = b[c_ROB_W-2:0];
        if (a[c_ROB_W-1] ^ b[c_ROB_W-1]) begin
            return a_idx < b_idx;
        end
        return a_idx > b_idx;
    endfunction

    function automatic logic ls_misaligned(input logic [2:0] addr, input ls_size_t size);
        return ((size == c_SIZE_H) && addr[0])
            || ((size == c_SIZE_W) && (addr[1:0] != 2'b00))
            || ((size == c_SIZE_D) && (addr != 3'b000));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ls_agu_if.sv
`default_nettype none
// ============================================================================
// Module   : ls_agu_if
// Brief    : Issue, AGU-result and flush signal bundle for the load/store AGU.
// Revision : 1.0 - initial release
// ============================================================================
interface ls_agu_if #(
    parameter int XLEN   = 64,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 7,
    parameter int SQ_W   = 5
);
    logic              issue_load0_valid;
    logic              issue_load0_ready;
    logic [PREG_W-1:0] issue_load0_prd;
    logic [XLEN-1:0]   issue_load0_imm;
    logic              issue_load0_is_unsigned;
    logic [3:0]        issue_load0_ls_size;
    logic [ROB_W-1:0]  issue_load0_robid;
    logic [XLEN-1:0]   load0_src1_data;

    logic              issue_st0_valid;
    logic              issue_st0_ready;
    logic [XLEN-1:0]   issue_st0_imm;
    logic [3:0]        issue_st0_ls_size;
    logic [ROB_W-1:0]  issue_st0_robid;
    logic [SQ_W-1:0]   issue_st0_sqid;
    logic [XLEN-1:0]   st0_src1_data;
    logic [XLEN-1:0]   st0_src2_data;

    logic              agu_load0_valid;
    logic              agu_load0_ready;
    logic [XLEN-1:0]   agu_load0_vaddr;
    logic [PREG_W-1:0] agu_load0_prd;
    logic [3:0]        agu_load0_size;
    logic              agu_load0_is_unsigned;
    logic [ROB_W-1:0]  agu_load0_robid;
    logic              agu_load0_misaligned;

    logic              agu_st0_valid;
    logic              agu_st0_ready;
    logic [XLEN-1:0]   agu_st0_vaddr;
    logic [XLEN-1:0]   agu_st0_wdata;
    logic [3:0]        agu_st0_size;
    logic [ROB_W-1:0]  agu_st0_robid;
    logic [SQ_W-1:0]   agu_st0_sqid;
    logic              agu_st0_misaligned;

    logic              flush_valid;
    logic [ROB_W-1:0]  flush_robid;
    logic [31:0]       agu_pmu_stall_cycle_cnt;

    modport slave (
        input  issue_load0_valid, issue_load0_prd, issue_load0_imm, issue_load0_is_unsigned,
               issue_load0_ls_size, issue_load0_robid, load0_src1_data,
               issue_st0_valid, issue_st0_imm, issue_st0_ls_size, issue_st0_robid,
               issue_st0_sqid, st0_src1_data, st0_src2_data,
               agu_load0_ready, agu_st0_ready, flush_valid, flush_robid,
        output issue_load0_ready, issue_st0_ready,
               agu_load0_valid, agu_load0_vaddr, agu_load0_prd, agu_load0_size,
               agu_load0_is_unsigned, agu_load0_robid, agu_load0_misaligned,
               agu_st0_valid, agu_st0_vaddr, agu_st0_wdata, agu_st0_size,
               agu_st0_robid, agu_st0_sqid, agu_st0_misaligned,
               agu_pmu_stall_cycle_cnt
    );

    modport master (
        output issue_load0_valid, issue_load0_prd, issue_load0_imm, issue_load0_is_unsigned,
               issue_load0_ls_size, issue_load0_robid, load0_src1_data,
               issue_st0_valid, issue_st0_imm, issue_st0_ls_size, issue_st0_robid,
               issue_st0_sqid, st0_src1_data, st0_src2_data,
               agu_load0_ready, agu_st0_ready, flush_valid, flush_robid,
        input  issue_load0_ready, issue_st0_ready,
               agu_load0_valid, agu_load0_vaddr, agu_load0_prd, agu_load0_size,
               agu_load0_is_unsigned, agu_load0_robid, agu_load0_misaligned,
               agu_st0_valid, agu_st0_vaddr, agu_st0_wdata, agu_st0_size,
               agu_st0_robid, agu_st0_sqid, agu_st0_misaligned,
               agu_pmu_stall_cycle_cnt
    );

endinterface
`default_nettype wire

// File: rtl/agu_slot.sv
`default_nettype none
// ============================================================================
// Module   : agu_slot
// Brief    : One-entry AGU result register with address add, misalign check
//            and flush kill; opaque payload carries port-specific sideband.
// Revision : 1.0 - initial release
// ============================================================================
module agu_slot
    import ls_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ROB_W     = 7,
    parameter int PAYLOAD_W = 1
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  i_valid,
    output logic                 o_ready,
    input  wire [XLEN-1:0]       i_src1,
    input  wire [XLEN-1:0]       i_imm,
    input  wire [3:0]            i_size,
    input  wire [ROB_W-1:0]      i_robid,
    input  wire [PAYLOAD_W-1:0]  i_payload,
    input  wire                  i_flush_valid,
    input  wire [ROB_W-1:0]      i_flush_robid,
    input  wire                  i_out_ready,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_vaddr,
    output logic [3:0]           o_size,
    output logic [ROB_W-1:0]     o_robid,
    output logic                 o_misaligned,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic                 r_valid;
    logic [XLEN-1:0]      r_vaddr;
    ls_size_t             r_size;
    logic [ROB_W-1:0]     r_robid;
    logic                 r_misaligned;
    logic [PAYLOAD_W-1:0] r_payload;

    logic            w_ready;
    logic            w_fire;
    logic            w_in_kill;
    logic            w_held_kill;
    logic [XLEN-1:0] w_vaddr;

    assign w_ready     = !r_valid || i_out_ready;
    assign w_fire      = i_valid && w_ready;
    assign w_vaddr     = i_src1 + i_imm;
    assign w_in_kill   = i_flush_valid && rob_younger(rob_id_t'(i_robid), rob_id_t'(i_flush_robid));
    assign w_held_kill = i_flush_valid && rob_younger(rob_id_t'(r_robid), rob_id_t'(i_flush_robid));

    // A killed incoming op still completes the handshake; only its valid is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_vaddr      <= '0;
            r_size       <= '0;
            r_robid      <= '0;
            r_misaligned <= 1'b0;
            r_payload    <= '0;
        end else if (w_fire) begin
            r_valid      <= !w_in_kill;
            r_vaddr      <= w_vaddr;
            r_size       <= i_size;
            r_robid      <= i_robid;
            r_misaligned <= ls_misaligned(w_vaddr[2:0], i_size);
            r_payload    <= i_payload;
        end else if (r_valid && (i_out_ready || w_held_kill)) begin
            r_valid      <= 1'b0;
        end
    end

    assign o_ready      = w_ready;
    assign o_valid      = r_valid;
    assign o_vaddr      = r_vaddr;
    assign o_size       = r_size;
    assign o_robid      = r_robid;
    assign o_misaligned = r_misaligned;
    assign o_payload    = r_payload;

endmodule
`default_nettype wire

// File: rtl/ls_agu.sv
`default_nettype none
// ============================================================================
// Module   : ls_agu
// Brief    : Load/store address generation: one load slot, one store slot,
//            flush squash and an issue-stall performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module ls_agu
    import ls_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 7,
    parameter int SQ_W   = 5
) (
    input  wire    clock,
    input  wire    reset_n,
    ls_agu_if.slave bus
);

    localparam int c_LD_PAY_W = PREG_W + 1;
    localparam int c_ST_PAY_W = XLEN + SQ_W;

    logic                  w_ld_ready;
    logic                  w_st_ready;
    logic                  w_ld_stall;
    logic                  w_st_stall;
    logic [c_LD_PAY_W-1:0] w_ld_pay_in;
    logic [c_LD_PAY_W-1:0] w_ld_pay_out;
    logic [c_ST_PAY_W-1:0] w_st_pay_in;
    logic [c_ST_PAY_W-1:0] w_st_pay_out;
    logic [31:0]           r_pmu_cnt;

    assign w_ld_pay_in = {bus.issue_load0_prd, bus.issue_load0_is_unsigned};
    assign w_st_pay_in = {bus.st0_src2_data, bus.issue_st0_sqid};

    agu_slot #(
        .XLEN      (XLEN),
        .ROB_W     (ROB_W),
        .PAYLOAD_W (c_LD_PAY_W)
    ) u_ld_slot (
        .clk           (clock),
        .rst_n         (reset_n),
        .i_valid       (bus.issue_load0_valid),
        .o_ready       (w_ld_ready),
        .i_src1        (bus.load0_src1_data),
        .i_imm         (bus.issue_load0_imm),
        .i_size        (bus.issue_load0_ls_size),
        .i_robid       (bus.issue_load0_robid),
        .i_payload     (w_ld_pay_in),
        .i_flush_valid (bus.flush_valid),
        .i_flush_robid (bus.flush_robid),
        .i_out_ready   (bus.agu_load0_ready),
        .o_valid       (bus.agu_load0_valid),
        .o_vaddr       (bus.agu_load0_vaddr),
        .o_size        (bus.agu_load0_size),
        .o_robid       (bus.agu_load0_robid),
        .o_misaligned  (bus.agu_load0_misaligned),
        .o_payload     (w_ld_pay_out)
    );

    agu_slot #(
        .XLEN      (XLEN),
        .ROB_W     (ROB_W),
        .PAYLOAD_W (c_ST_PAY_W)
    ) u_st_slot (
        .clk           (clock),
        .rst_n         (reset_n),
        .i_valid       (bus.issue_st0_valid),
        .o_ready       (w_st_ready),
        .i_src1        (bus.st0_src1_data),
        .i_imm         (bus.issue_st0_imm),
        .i_size        (bus.issue_st0_ls_size),
        .i_robid       (bus.issue_st0_robid),
        .i_payload     (w_st_pay_in),
        .i_flush_valid (bus.flush_valid),
        .i_flush_robid (bus.flush_robid),
        .i_out_ready   (bus.agu_st0_ready),
        .o_valid       (bus.agu_st0_valid),
        .o_vaddr       (bus.agu_st0_vaddr),
        .o_size        (bus.agu_st0_size),
        .o_robid       (bus.agu_st0_robid),
        .o_misaligned  (bus.agu_st0_misaligned),
        .o_payload     (w_st_pay_out)
    );

    assign bus.issue_load0_ready     = w_ld_ready;
    assign bus.issue_st0_ready       = w_st_ready;
    assign bus.agu_load0_prd         = w_ld_pay_out[c_LD_PAY_W-1:1];
    assign bus.agu_load0_is_unsigned = w_ld_pay_out[0];
    assign bus.agu_st0_wdata         = w_st_pay_out[c_ST_PAY_W-1:SQ_W];
    assign bus.agu_st0_sqid          = w_st_pay_out[SQ_W-1:0];

    assign w_ld_stall = bus.issue_load0_valid && !w_ld_ready;
    assign w_st_stall = bus.issue_st0_valid && !w_st_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pmu_cnt <= '0;
        end else begin
            r_pmu_cnt <= r_pmu_cnt + 32'(w_ld_stall) + 32'(w_st_stall);
        end
    end

    assign bus.agu_pmu_stall_cycle_cnt = r_pmu_cnt;

endmodule
`default_nettype wire
